// File: rtl/bus_dma_master.sv
// bus_dma_master: word-copy DMA engine with a CPU-side register port
// (SRC/DST/CNT/CTL) and a bus master port that the top level muxes onto
// the shared bus while MGNT is high.
// Optional feature macro: DMA_FILL_EN enables the CTL Fill bit, which turns
// the copy into a pattern fill (SRC value written to every destination word).
module bus_dma_master #(
  parameter int               ABITS = 32,
  parameter int               DBITS = 32,
  parameter logic [ABITS-1:0] RBASE = ABITS'('hF0000040)
) (
  input  logic             CLK,
  input  logic             INIT,
  input  logic             LOCK,
  input  logic [ABITS-1:0] ABUS,
  inout  wire  [DBITS-1:0] RBUS,
  input  logic             RE,
  input  logic [DBITS-1:0] WBUS,
  input  logic             WE,
  output logic             INTR,
  output logic             MREQ,
  input  logic             MGNT,
  output logic [ABITS-1:0] MABUS,
  input  logic [DBITS-1:0] MRBUS,
  output logic [DBITS-1:0] MWBUS,
  output logic             MRE,
  output logic             MWE
);

  typedef enum logic [1:0] {IDLE, REQ, READ, WRITE} state_t;

  localparam logic [ABITS-1:0] WSTEP = ABITS'(DBITS / 8);
  localparam logic [ABITS-1:0] A_SRC = RBASE;
  localparam logic [ABITS-1:0] A_DST = RBASE + ABITS'(4);
  localparam logic [ABITS-1:0] A_CNT = RBASE + ABITS'(8);
  localparam logic [ABITS-1:0] A_CTL = RBASE + ABITS'(12);

  state_t           state;
  state_t           nxt;
  logic [ABITS-1:0] src;
  logic [ABITS-1:0] dst;
  logic [DBITS-1:0] cnt;
  logic [DBITS-1:0] rdbuf;
  logic [DBITS-1:0] rdata;
  logic             rdy;
  logic             ovr;
  logic             ie;
  logic             fill;
  logic             busy;
  logic             last;
  logic             sel;
  logic             wr_ctl;
  logic             start;
  logic             complete;
  logic             unused_wbus;

  assign wr_ctl   = WE && (ABUS == A_CTL);
  assign start    = wr_ctl && WBUS[8];
  assign busy     = (state != IDLE);
  assign last     = (cnt == DBITS'(1));
  assign complete = (state == WRITE) && last;
  assign INTR     = rdy && ie;

  // Slave register read mux; the bus is released unless one of our registers is read
  always_comb begin
    rdata = '0;
    sel   = 1'b0;
    if (ABUS == A_SRC) begin
      sel   = 1'b1;
      rdata = DBITS'(src);
    end else if (ABUS == A_DST) begin
      sel   = 1'b1;
      rdata = DBITS'(dst);
    end else if (ABUS == A_CNT) begin
      sel   = 1'b1;
      rdata = cnt;
    end else if (ABUS == A_CTL) begin
      sel   = 1'b1;
      rdata = DBITS'({fill, ie, 1'b0, busy, ovr, rdy});
    end
  end

  assign RBUS = (RE && sel) ? rdata : {DBITS{1'bz}};

  // State register; a PLL that is not locked freezes the engine
  always_ff @(posedge CLK or posedge INIT) begin
    if (INIT) begin
      state <= IDLE;
    end else if (LOCK) begin
      state <= nxt;
    end
  end

  // Next state and master port strobes; fill mode skips the read phase
  always_comb begin
    nxt   = state;
    MREQ  = 1'b0;
    MRE   = 1'b0;
    MWE   = 1'b0;
    MABUS = '0;
    MWBUS = '0;
    case (state)
      IDLE: begin
        if (start && (cnt != '0)) nxt = REQ;
      end
      REQ: begin
        MREQ = 1'b1;
        if (MGNT) nxt = fill ? WRITE : READ;
      end
      READ: begin
        MREQ  = 1'b1;
        MRE   = 1'b1;
        MABUS = src;
        nxt   = WRITE;
      end
      WRITE: begin
        MREQ  = 1'b1;
        MWE   = 1'b1;
        MABUS = dst;
        MWBUS = fill ? DBITS'(src) : rdbuf;
        if (last) nxt = IDLE;
        else      nxt = fill ? WRITE : READ;
      end
      default: nxt = IDLE;
    endcase
  end

  // Address/count registers, read buffer and status flags; set events are
  // applied after CTL clears so a completion or overrun is never lost
  always_ff @(posedge CLK or posedge INIT) begin
    if (INIT) begin
      src   <= '0;
      dst   <= '0;
      cnt   <= '0;
      rdbuf <= '0;
      rdy   <= 1'b0;
      ovr   <= 1'b0;
      ie    <= 1'b0;
    end else if (LOCK) begin
      if (WE && !busy) begin
        if (ABUS == A_SRC) src <= ABITS'(WBUS);
        if (ABUS == A_DST) dst <= ABITS'(WBUS);
        if (ABUS == A_CNT) cnt <= WBUS;
      end
      if (state == READ) rdbuf <= MRBUS;
      if (state == WRITE) begin
        if (!fill) src <= src + WSTEP;
        dst <= dst + WSTEP;
        cnt <= cnt - DBITS'(1);
      end
      if (wr_ctl) begin
        if (!WBUS[0]) rdy <= 1'b0;
        if (!WBUS[1]) ovr <= 1'b0;
        ie <= WBUS[4];
      end
      if (start) begin
        if (busy) begin
          ovr <= 1'b1;
        end else if (cnt == '0) begin
          rdy <= 1'b1;
          if (rdy) ovr <= 1'b1;
        end
      end
      if (complete) begin
        rdy <= 1'b1;
        if (rdy) ovr <= 1'b1;
      end
    end
  end

`ifdef DMA_FILL_EN
  // Fill mode bit; frozen while a transfer is running
  always_ff @(posedge CLK or posedge INIT) begin
    if (INIT) begin
      fill <= 1'b0;
    end else if (LOCK && wr_ctl && !busy) begin
      fill <= WBUS[5];
    end
  end
  assign unused_wbus = ^{WBUS[DBITS-1:9], WBUS[7:6], WBUS[3:2]};
`else
  assign fill        = 1'b0;
  assign unused_wbus = ^{WBUS[DBITS-1:9], WBUS[7:5], WBUS[3:2]};
`endif

  // The arbiter must keep the grant for the whole burst once it has been given
  assert property (@(posedge CLK) disable iff (INIT) ((state == READ) || (state == WRITE)) |-> MGNT);

endmodule

// File: tb/tb_bus_dma_master.sv
// tb_bus_dma_master: scoreboard bench for the DMA engine. Expected master
// writes are queued when a transfer is started and compared against the
// writes observed on the master port once the transfer finishes.
module tb_bus_dma_master;

  localparam logic [31:0] R_SRC = 32'hF0000040;
  localparam logic [31:0] R_DST = 32'hF0000044;
  localparam logic [31:0] R_CNT = 32'hF0000048;
  localparam logic [31:0] R_CTL = 32'hF000004C;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        init;
  logic        lock;
  logic [31:0] aBus;
  wire  [31:0] rBus;
  logic        re;
  logic [31:0] wBus;
  logic        we;
  logic        intr;
  logic        mReq;
  logic        mGnt;
  logic [31:0] mABus;
  logic [31:0] mRBus;
  logic [31:0] mWBus;
  logic        mRe;
  logic        mWe;

  int  nChecks = 0;
  int  nFails = 0;
  int  mreqCount = 0;
  int  mreCount = 0;
  int  mweCount = 0;
  int  altErrCount = 0;
  int  noGrantCount = 0;
  bit  lastRead = 1'b0;
  int  obsIdx = 0;
  wr_t expQ[$];
  wr_t obsQ[$];
  logic [31:0] mem [int];

  bus_dma_master dut (
    .CLK(clk), .INIT(init), .LOCK(lock), .ABUS(aBus), .RBUS(rBus), .RE(re),
    .WBUS(wBus), .WE(we), .INTR(intr), .MREQ(mReq), .MGNT(mGnt), .MABUS(mABus),
    .MRBUS(mRBus), .MWBUS(mWBus), .MRE(mRe), .MWE(mWe)
  );

  always #5 clk = ~clk;

  // Source memory contents are a fixed function of the address
  function automatic logic [31:0] pat(input logic [31:0] a);
    return 32'hC0DE0000 ^ (a * 32'd3);
  endfunction

  assign mRBus = mRe ? pat(mABus) : 32'h0;

  // Destination memory model
  always @(posedge clk) begin
    if (mWe && lock && !init) mem[int'(mABus)] = mWBus;
  end

  // Master port monitor: counts strobes and records every write
  always @(negedge clk) begin
    if (mReq) mreqCount++;
    if (mRe) mreCount++;
    if (mWe) begin
      mweCount++;
      obsQ.push_back({mABus, mWBus});
    end
    if ((mRe || mWe) && !mGnt) noGrantCount++;
    if (mRe && mWe) altErrCount++;
    else if (mRe) begin
      if (lastRead) altErrCount++;
      lastRead = 1'b1;
    end else if (mWe) begin
      if (!lastRead) altErrCount++;
      lastRead = 1'b0;
    end
  end

  task automatic busWrite(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    aBus = addr;
    wBus = data;
    we   = 1'b1;
    @(posedge clk);
    #1;
    we   = 1'b0;
  endtask

  task automatic readNow(input logic [31:0] addr, output logic [31:0] data);
    aBus = addr;
    re   = 1'b1;
    #1;
    data = rBus;
    re   = 1'b0;
  endtask

  task automatic busRead(input logic [31:0] addr, output logic [31:0] data);
    @(negedge clk);
    readNow(addr, data);
  endtask

  task automatic waitIdle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #2;
      if (!mReq) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    #3;
    nChecks++; if ({mReq, mRe, mWe, intr} !== 4'b0) begin nFails++; $display("[TB] FAIL reset_strobes got=%b exp=0000", {mReq, mRe, mWe, intr}); end
    nChecks++; if (mABus !== 32'h0 || mWBus !== 32'h0) begin nFails++; $display("[TB] FAIL reset_mbus got=%h/%h exp=0/0", mABus, mWBus); end
    readNow(R_SRC, rd);
    nChecks++; if (rd !== 32'h0) begin nFails++; $display("[TB] FAIL reset_src got=%h exp=0", rd); end
    readNow(R_CNT, rd);
    nChecks++; if (rd !== 32'h0) begin nFails++; $display("[TB] FAIL reset_cnt got=%h exp=0", rd); end
    readNow(R_CTL, rd);
    nChecks++; if (rd !== 32'h0) begin nFails++; $display("[TB] FAIL reset_ctl got=%h exp=0", rd); end
    @(negedge clk);
    init = 1'b0;
  endtask

  task automatic test_lock();
    logic [31:0] rd;
    busWrite(R_SRC, 32'h1234);
    lock = 1'b0;
    busWrite(R_SRC, 32'h5555);
    busWrite(R_CTL, 32'h100);
    lock = 1'b1;
    busRead(R_SRC, rd);
    nChecks++; if (rd !== 32'h1234) begin nFails++; $display("[TB] FAIL lock_src got=%h exp=%h", rd, 32'h1234); end
    busRead(R_CTL, rd);
    nChecks++; if (rd !== 32'h0) begin nFails++; $display("[TB] FAIL lock_ctl got=%h exp=0", rd); end
  endtask

  task automatic test_copy();
    int mre0, mwe0, mreq0, alt0;
    bit ok;
    logic [31:0] rd;
    wr_t e, o;
    mGnt = 1'b1;
    busWrite(R_SRC, 32'h100);
    busWrite(R_DST, 32'h200);
    busWrite(R_CNT, 32'd4);
    for (int i = 0; i < 4; i++) expQ.push_back({32'h200 + 32'(4 * i), pat(32'h100 + 32'(4 * i))});
    mre0 = mreCount; mwe0 = mweCount; mreq0 = mreqCount; alt0 = altErrCount;
    busWrite(R_CTL, 32'h100);
    waitIdle(ok);
    nChecks++; if (!ok) begin nFails++; $display("[TB] FAIL copy_timeout got=busy exp=idle"); end
    nChecks++; if (mreqCount - mreq0 !== 9) begin nFails++; $display("[TB] FAIL copy_mreq_cycles got=%0d exp=9", mreqCount - mreq0); end
    nChecks++; if (mreCount - mre0 !== 4 || mweCount - mwe0 !== 4) begin nFails++; $display("[TB] FAIL copy_strobes got=%0d/%0d exp=4/4", mreCount - mre0, mweCount - mwe0); end
    nChecks++; if (altErrCount - alt0 !== 0) begin nFails++; $display("[TB] FAIL copy_alternate got=%0d exp=0", altErrCount - alt0); end
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      nChecks++;
      if (obsIdx >= obsQ.size()) begin nFails++; $display("[TB] FAIL copy_write got=none exp=%h@%h", e.data, e.addr); end
      else begin
        o = obsQ[obsIdx]; obsIdx++;
        if (o !== e) begin nFails++; $display("[TB] FAIL copy_write got=%h@%h exp=%h@%h", o.data, o.addr, e.data, e.addr); end
      end
    end
    for (int i = 0; i < 4; i++) begin
      nChecks++;
      if (!mem.exists(32'h200 + 4 * i) || mem[32'h200 + 4 * i] !== pat(32'h100 + 32'(4 * i))) begin
        nFails++; $display("[TB] FAIL copy_mem[%0d] got=missing_or_wrong exp=%h", i, pat(32'h100 + 32'(4 * i)));
      end
    end
    busRead(R_SRC, rd);
    nChecks++; if (rd !== 32'h110) begin nFails++; $display("[TB] FAIL copy_src got=%h exp=110", rd); end
    busRead(R_DST, rd);
    nChecks++; if (rd !== 32'h210) begin nFails++; $display("[TB] FAIL copy_dst got=%h exp=210", rd); end
    busRead(R_CNT, rd);
    nChecks++; if (rd !== 32'h0) begin nFails++; $display("[TB] FAIL copy_cnt got=%h exp=0", rd); end
    busRead(R_CTL, rd);
    nChecks++; if (rd !== 32'h1) begin nFails++; $display("[TB] FAIL copy_ctl got=%h exp=1", rd); end
    nChecks++; if (mReq !== 1'b0 || intr !== 1'b0) begin nFails++; $display("[TB] FAIL copy_mreq_intr got=%b%b exp=00", mReq, intr); end
    mGnt = 1'b0;
  endtask

  task automatic test_grant_delay();
    int mre0, mwe0, ng0;
    bit ok;
    logic [31:0] rd;
    wr_t e, o;
    mGnt = 1'b0;
    busWrite(R_SRC, 32'h120);
    busWrite(R_DST, 32'h240);
    busWrite(R_CNT, 32'd1);
    expQ.push_back({32'h240, pat(32'h120)});
    mre0 = mreCount; mwe0 = mweCount; ng0 = noGrantCount;
    busWrite(R_CTL, 32'h110);
    repeat (5) @(posedge clk);
    #2;
    nChecks++; if (mReq !== 1'b1) begin nFails++; $display("[TB] FAIL grant_wait_mreq got=%b exp=1", mReq); end
    nChecks++; if (mreCount - mre0 !== 0 || mweCount - mwe0 !== 0) begin nFails++; $display("[TB] FAIL grant_early_strobe got=%0d/%0d exp=0/0", mreCount - mre0, mweCount - mwe0); end
    @(negedge clk);
    mGnt = 1'b1;
    waitIdle(ok);
    nChecks++; if (!ok) begin nFails++; $display("[TB] FAIL grant_timeout got=busy exp=idle"); end
    nChecks++; if (mreCount - mre0 !== 1 || mweCount - mwe0 !== 1 || noGrantCount - ng0 !== 0) begin nFails++; $display("[TB] FAIL grant_strobes got=%0d/%0d/%0d exp=1/1/0", mreCount - mre0, mweCount - mwe0, noGrantCount - ng0); end
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      nChecks++;
      if (obsIdx >= obsQ.size()) begin nFails++; $display("[TB] FAIL grant_write got=none exp=%h@%h", e.data, e.addr); end
      else begin
        o = obsQ[obsIdx]; obsIdx++;
        if (o !== e) begin nFails++; $display("[TB] FAIL grant_write got=%h@%h exp=%h@%h", o.data, o.addr, e.data, e.addr); end
      end
    end
    nChecks++; if (intr !== 1'b1) begin nFails++; $display("[TB] FAIL grant_intr_set got=%b exp=1", intr); end
    mGnt = 1'b0;
    busWrite(R_CTL, 32'h10);
    nChecks++; if (intr !== 1'b0) begin nFails++; $display("[TB] FAIL grant_intr_clear got=%b exp=0", intr); end
    busRead(R_CTL, rd);
    nChecks++; if (rd !== 32'h10) begin nFails++; $display("[TB] FAIL grant_ctl got=%h exp=10", rd); end
  endtask

  task automatic test_zero_count();
    int mreq0;
    logic [31:0] rd;
    busWrite(R_CTL, 32'h0);
    busWrite(R_CNT, 32'h0);
    mreq0 = mreqCount;
    busWrite(R_CTL, 32'h100);
    readNow(R_CTL, rd);
    nChecks++; if (rd !== 32'h1) begin nFails++; $display("[TB] FAIL zero_rdy got=%h exp=1", rd); end
    repeat (3) @(posedge clk);
    nChecks++; if (mreqCount - mreq0 !== 0) begin nFails++; $display("[TB] FAIL zero_no_mreq got=%0d exp=0", mreqCount - mreq0); end
    busWrite(R_CTL, 32'h100);
    busRead(R_CTL, rd);
    nChecks++; if (rd !== 32'h3) begin nFails++; $display("[TB] FAIL zero_ovr got=%h exp=3", rd); end
    busWrite(R_CTL, 32'h0);
    busRead(R_CTL, rd);
    nChecks++; if (rd !== 32'h0) begin nFails++; $display("[TB] FAIL zero_clear got=%h exp=0", rd); end
  endtask

  task automatic test_busy_ignore();
    int mre0;
    bit ok;
    logic [31:0] rd;
    wr_t e, o;
    mGnt = 1'b1;
    busWrite(R_SRC, 32'h100);
    busWrite(R_DST, 32'h280);
    busWrite(R_CNT, 32'd3);
    for (int i = 0; i < 3; i++) expQ.push_back({32'h280 + 32'(4 * i), pat(32'h100 + 32'(4 * i))});
    mre0 = mreCount;
    busWrite(R_CTL, 32'h100);
    busWrite(R_DST, 32'h999);
    busWrite(R_CTL, 32'h100);
    waitIdle(ok);
    nChecks++; if (!ok) begin nFails++; $display("[TB] FAIL busy_timeout got=busy exp=idle"); end
    nChecks++; if (mreCount - mre0 !== 3) begin nFails++; $display("[TB] FAIL busy_reads got=%0d exp=3", mreCount - mre0); end
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      nChecks++;
      if (obsIdx >= obsQ.size()) begin nFails++; $display("[TB] FAIL busy_write got=none exp=%h@%h", e.data, e.addr); end
      else begin
        o = obsQ[obsIdx]; obsIdx++;
        if (o !== e) begin nFails++; $display("[TB] FAIL busy_write got=%h@%h exp=%h@%h", o.data, o.addr, e.data, e.addr); end
      end
    end
    busRead(R_DST, rd);
    nChecks++; if (rd !== 32'h28C) begin nFails++; $display("[TB] FAIL busy_dst got=%h exp=28c", rd); end
    busRead(R_CTL, rd);
    nChecks++; if (rd !== 32'h3) begin nFails++; $display("[TB] FAIL busy_ctl got=%h exp=3", rd); end
    mGnt = 1'b0;
    busWrite(R_CTL, 32'h0);
  endtask

`ifdef DMA_FILL_EN
  task automatic test_fill();
    int mre0, mwe0, mreq0;
    bit ok;
    logic [31:0] rd;
    wr_t e, o;
    busWrite(R_CTL, 32'h20);
    busWrite(R_SRC, 32'hA5A5A5A5);
    busWrite(R_DST, 32'h300);
    busWrite(R_CNT, 32'd3);
    mGnt = 1'b1;
    for (int i = 0; i < 3; i++) expQ.push_back({32'h300 + 32'(4 * i), 32'hA5A5A5A5});
    mre0 = mreCount; mwe0 = mweCount; mreq0 = mreqCount;
    busWrite(R_CTL, 32'h120);
    waitIdle(ok);
    nChecks++; if (!ok) begin nFails++; $display("[TB] FAIL fill_timeout got=busy exp=idle"); end
    nChecks++; if (mreCount - mre0 !== 0 || mweCount - mwe0 !== 3) begin nFails++; $display("[TB] FAIL fill_strobes got=%0d/%0d exp=0/3", mreCount - mre0, mweCount - mwe0); end
    nChecks++; if (mreqCount - mreq0 !== 4) begin nFails++; $display("[TB] FAIL fill_mreq_cycles got=%0d exp=4", mreqCount - mreq0); end
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      nChecks++;
      if (obsIdx >= obsQ.size()) begin nFails++; $display("[TB] FAIL fill_write got=none exp=%h@%h", e.data, e.addr); end
      else begin
        o = obsQ[obsIdx]; obsIdx++;
        if (o !== e) begin nFails++; $display("[TB] FAIL fill_write got=%h@%h exp=%h@%h", o.data, o.addr, e.data, e.addr); end
      end
    end
    busRead(R_SRC, rd);
    nChecks++; if (rd !== 32'hA5A5A5A5) begin nFails++; $display("[TB] FAIL fill_src got=%h exp=a5a5a5a5", rd); end
    busRead(R_DST, rd);
    nChecks++; if (rd !== 32'h30C) begin nFails++; $display("[TB] FAIL fill_dst got=%h exp=30c", rd); end
    busRead(R_CTL, rd);
    nChecks++; if (rd !== 32'h21) begin nFails++; $display("[TB] FAIL fill_ctl got=%h exp=21", rd); end
    mGnt = 1'b0;
    busWrite(R_CTL, 32'h0);
  endtask
`else
  task automatic test_fill_disabled();
    logic [31:0] rd;
    busWrite(R_CTL, 32'h20);
    busRead(R_CTL, rd);
    nChecks++; if (rd !== 32'h0) begin nFails++; $display("[TB] FAIL fill_bit_readback got=%h exp=0", rd); end
  endtask
`endif

  task automatic test_init_abort();
    int mwe0;
    bit seen;
    logic [31:0] rd;
    mGnt = 1'b1;
    busWrite(R_SRC, 32'h100);
    busWrite(R_DST, 32'h2C0);
    busWrite(R_CNT, 32'd4);
    mwe0 = mweCount;
    busWrite(R_CTL, 32'h110);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #2;
      if (mweCount - mwe0 >= 1) begin
        seen = 1'b1;
        break;
      end
    end
    nChecks++; if (!seen) begin nFails++; $display("[TB] FAIL abort_first_write got=none exp=one"); end
    #1;
    init = 1'b1;
    #1;
    nChecks++; if ({mReq, mRe, mWe} !== 3'b000) begin nFails++; $display("[TB] FAIL abort_strobes got=%b exp=000", {mReq, mRe, mWe}); end
    nChecks++; if (mABus !== 32'h0 || mWBus !== 32'h0) begin nFails++; $display("[TB] FAIL abort_mbus got=%h/%h exp=0/0", mABus, mWBus); end
    readNow(R_SRC, rd);
    nChecks++; if (rd !== 32'h0) begin nFails++; $display("[TB] FAIL abort_src got=%h exp=0", rd); end
    readNow(R_DST, rd);
    nChecks++; if (rd !== 32'h0) begin nFails++; $display("[TB] FAIL abort_dst got=%h exp=0", rd); end
    readNow(R_CNT, rd);
    nChecks++; if (rd !== 32'h0) begin nFails++; $display("[TB] FAIL abort_cnt got=%h exp=0", rd); end
    readNow(R_CTL, rd);
    nChecks++; if (rd !== 32'h0) begin nFails++; $display("[TB] FAIL abort_ctl got=%h exp=0", rd); end
    #1;
    init = 1'b0;
    mGnt = 1'b0;
    obsIdx = obsQ.size();
    repeat (3) @(posedge clk);
    #2;
    nChecks++; if (mReq !== 1'b0) begin nFails++; $display("[TB] FAIL abort_stays_idle got=%b exp=0", mReq); end
    nChecks++;
    if (!mem.exists(32'h2C0) || mem[32'h2C0] !== pat(32'h100)) begin nFails++; $display("[TB] FAIL abort_partial_mem got=missing_or_wrong exp=%h", pat(32'h100)); end
  endtask

  initial begin
    init = 1'b1;
    lock = 1'b1;
    aBus = 32'h0;
    wBus = 32'h0;
    re   = 1'b0;
    we   = 1'b0;
    mGnt = 1'b0;
    $display("[TB] starting bus_dma_master bench");
    test_reset();
    test_lock();
    test_copy();
    test_grant_delay();
    test_zero_count();
    test_busy_ignore();
`ifdef DMA_FILL_EN
    test_fill();
`else
    test_fill_disabled();
`endif
    test_init_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
